// File: rtl/pipe_mux_stage.sv
// pipe_mux_stage: NUM_IN-way WIDTH-bit selector feeding a registered
// valid/ready stage with a 2-entry skid buffer (main + skid register).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_data    packed inputs, input k at [k*WIDTH +: WIDTH]
//   sel        input select, sampled with in_data on acceptance
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat (registered, state-only)
//   flush      synchronous squash of all held beats
//   out_data   selected, registered data
//   out_sel    select value that produced out_data
//   out_valid  out_data valid
//   out_ready  downstream accepts
//   sel_err    one-cycle pulse: an accepted beat had sel >= NUM_IN
module pipe_mux_stage #(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      NUM_IN = 4,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int unsigned      SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic [SEL_W-1:0]   main_sel_q, main_sel_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [SEL_W-1:0]   skid_sel_q, skid_sel_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               sel_err_q, sel_err_d;

  logic [WIDTH-1:0]   pick_data;
  logic               sel_bad;
  logic               accept;
  logic               take;

  assign accept = in_valid & in_ready_q;
  assign take   = out_valid_q & out_ready;

  // Input selector; an unmatched select yields BUBBLE and flags sel_bad.
  always_comb begin
    pick_data = BUBBLE;
    sel_bad   = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        pick_data = in_data[k*WIDTH +: WIDTH];
        sel_bad   = 1'b0;
      end
    end
  end

  // State register plus datapath/handshake registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= BUBBLE;
      main_sel_q  <= '0;
      skid_data_q <= BUBBLE;
      skid_sel_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = ONE;
        ONE: begin
          if (accept && !take)      state_d = FULL;
          else if (take && !accept) state_d = EMPTY;
        end
        FULL:    if (take) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Register next values; in_ready/out_valid follow the next state so they
  // stay registered with no combinational path from the inputs.
  always_comb begin
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    if (flush) begin
      main_data_d = BUBBLE;
      main_sel_d  = '0;
      skid_data_d = BUBBLE;
      skid_sel_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_data_d = pick_data;
            main_sel_d  = sel;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_data_d = pick_data;
            main_sel_d  = sel;
          end else if (accept) begin
            skid_data_d = pick_data;
            skid_sel_d  = sel;
          end
        end
        FULL: begin
          if (take) begin
            main_data_d = skid_data_q;
            main_sel_d  = skid_sel_q;
            skid_data_d = BUBBLE;
            skid_sel_d  = '0;
          end
        end
        default: begin
          main_data_d = BUBBLE;
          main_sel_d  = '0;
        end
      endcase
    end
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    sel_err_d   = accept & ~flush & sel_bad;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_pipe_mux_stage.sv
// Bench for pipe_mux_stage: a 4-input instance checked every cycle against a
// queue-based reference model, and a 3-input instance for bad-select cases.
module tb_pipe_mux_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   sel;

  logic [127:0] in_data4;
  logic         in_valid4, in_ready4, flush4, out_valid4, out_ready4, sel_err4;
  logic [31:0]  out_data4;
  logic [1:0]   out_sel4;

  logic [95:0]  in_data3;
  logic         in_valid3, in_ready3, flush3, out_valid3, out_ready3, sel_err3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;

  always #5 clk = ~clk;

  pipe_mux_stage #(.WIDTH(32), .NUM_IN(4)) u4 (
    .clk(clk), .reset(reset), .in_data(in_data4), .sel(sel),
    .in_valid(in_valid4), .in_ready(in_ready4), .flush(flush4),
    .out_data(out_data4), .out_sel(out_sel4), .out_valid(out_valid4),
    .out_ready(out_ready4), .sel_err(sel_err4)
  );

  pipe_mux_stage #(.WIDTH(32), .NUM_IN(3)) u3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .sel(sel),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_sel(out_sel3), .out_valid(out_valid3),
    .out_ready(out_ready3), .sel_err(sel_err3)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  s;
  } item_t;

  int          checks   = 0;
  int          failures = 0;
  item_t       q[$];
  logic [31:0] last_d;
  logic [1:0]  last_s;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_d  = 32'h0;
    last_s  = 2'd0;
    exp_err = 1'b0;
  endtask

  // Transaction-level view: the stage is a FIFO of depth 2.
  task automatic model_edge();
    bit    acc;
    bit    tk;
    item_t it;
    acc = in_valid4 && (q.size() < 2);
    tk  = (q.size() > 0) && out_ready4;
    if (flush4) begin
      model_reset();
    end else begin
      exp_err = acc && (int'(sel) >= 4);
      if (tk) begin
        last_d = q[0].d;
        last_s = q[0].s;
        void'(q.pop_front());
      end
      if (acc) begin
        it.d = (int'(sel) < 4) ? in_data4[int'(sel)*32 +: 32] : 32'h0;
        it.s = sel;
        q.push_back(it);
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] ed;
    logic [1:0]  es;
    if (q.size() > 0) begin
      ed = q[0].d;
      es = q[0].s;
    end else begin
      ed = last_d;
      es = last_s;
    end
    chk({tag, ".in_ready"},  32'(in_ready4),  32'(q.size() < 2));
    chk({tag, ".out_valid"}, 32'(out_valid4), 32'(q.size() > 0));
    chk({tag, ".out_data"},  out_data4,       ed);
    chk({tag, ".out_sel"},   32'(out_sel4),   32'(es));
    chk({tag, ".sel_err"},   32'(sel_err4),   32'(exp_err));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic fixed_words();
    in_data4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_data3 = {32'h33333333, 32'h22222222, 32'h11111111};
  endtask

  initial begin
    reset = 1'b1;
    sel = 2'd0;
    in_valid4 = 1'b0; flush4 = 1'b0; out_ready4 = 1'b0;
    in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b0;
    fixed_words();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    chk("reset.u3_in_ready", 32'(in_ready3), 32'd1);
    chk("reset.u3_out_valid", 32'(out_valid3), 32'd0);
    chk("reset.u3_sel_err", 32'(sel_err3), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Basic select
    sel = 2'd2; in_valid4 = 1'b1; out_ready4 = 1'b1;
    step("basic");
    chk("basic.data", out_data4, 32'h33333333);
    chk("basic.sel", 32'(out_sel4), 32'd2);
    in_valid4 = 1'b0;
    step("basic_drain");

    // Streaming at one beat per cycle
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); in_valid4 = 1'b1;
      step("stream");
      chk("stream.data", out_data4, 32'h11111111 * 32'(s + 1));
      chk("stream.in_ready", 32'(in_ready4), 32'd1);
    end
    in_valid4 = 1'b0;
    step("stream_drain");

    // Backpressure fills the skid buffer
    out_ready4 = 1'b0; in_valid4 = 1'b1; sel = 2'd0;
    step("bp_a");
    sel = 2'd1;
    step("bp_b");
    chk("bp.in_ready_low", 32'(in_ready4), 32'd0);
    in_valid4 = 1'b0;
    step("bp_hold");
    chk("bp.hold_data", out_data4, 32'h11111111);
    out_ready4 = 1'b1;
    step("bp_take1");
    chk("bp.second", out_data4, 32'h22222222);
    step("bp_take2");
    chk("bp.in_ready_back", 32'(in_ready4), 32'd1);

    // Flush from FULL with a beat offered
    out_ready4 = 1'b0; in_valid4 = 1'b1; sel = 2'd0;
    step("fl_a");
    sel = 2'd1;
    step("fl_b");
    sel = 2'd3; flush4 = 1'b1;
    step("fl_full");
    chk("flush.out_valid", 32'(out_valid4), 32'd0);
    chk("flush.bubble", out_data4, 32'h0);
    flush4 = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b1;
    repeat (3) begin
      step("fl_after");
      chk("flush.no_44", 32'(out_data4 == 32'h44444444), 32'd0);
    end

    // Flush from ONE while accept is true: offered beat discarded
    out_ready4 = 1'b0; in_valid4 = 1'b1; sel = 2'd1;
    step("fl1_a");
    sel = 2'd3; flush4 = 1'b1;
    step("fl1_flush");
    chk("flush1.out_valid", 32'(out_valid4), 32'd0);
    flush4 = 1'b0; in_valid4 = 1'b0;
    step("fl1_idle");

    // Bad select on the 3-input instance
    sel = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b1;
    step("bad");
    chk("bad.out_valid", 32'(out_valid3), 32'd1);
    chk("bad.bubble", out_data3, 32'h0);
    chk("bad.out_sel", 32'(out_sel3), 32'd3);
    chk("bad.sel_err", 32'(sel_err3), 32'd1);
    in_valid3 = 1'b0;
    step("bad_after");
    chk("bad.pulse_end", 32'(sel_err3), 32'd0);
    in_valid3 = 1'b1; flush3 = 1'b1;
    step("bad_flush");
    chk("bad_flush.sel_err", 32'(sel_err3), 32'd0);
    chk("bad_flush.out_valid", 32'(out_valid3), 32'd0);
    flush3 = 1'b0; sel = 2'd2;
    step("good3");
    chk("good3.data", out_data3, 32'h33333333);
    chk("good3.sel_err", 32'(sel_err3), 32'd0);
    in_valid3 = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_data4   = {$urandom(), $urandom(), $urandom(), $urandom()};
      sel        = 2'($urandom_range(0, 3));
      in_valid4  = ($urandom_range(0, 3) != 0);
      out_ready4 = ($urandom_range(0, 2) != 0);
      flush4     = ($urandom_range(0, 15) == 0);
      step("rand");
    end
    flush4 = 1'b0;

    // Asynchronous reset in FULL
    fixed_words();
    out_ready4 = 1'b0; in_valid4 = 1'b1; sel = 2'd0;
    step("ar_a");
    sel = 2'd1;
    step("ar_b");
    chk("ar.full", 32'(in_ready4), 32'd0);
    #2;
    reset = 1'b1;
    in_valid4 = 1'b0;
    #1;
    chk("ar.out_valid", 32'(out_valid4), 32'd0);
    chk("ar.in_ready", 32'(in_ready4), 32'd1);
    chk("ar.bubble", out_data4, 32'h0);
    model_reset();
    #2;
    reset = 1'b0;
    in_valid4 = 1'b1; sel = 2'd1; out_ready4 = 1'b1;
    step("ar_first");
    chk("ar.first_data", out_data4, 32'h22222222);
    chk("ar.first_valid", 32'(out_valid4), 32'd1);
    in_valid4 = 1'b0;
    step("ar_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
